uart_alu_intf: RTL and testbench
================================

Name: uart_alu_intf

Overview:
- Glue stage between the UART receiver/transmitter and the combinational ALU in the UART-TP top.
- Collects three received bytes in order: operand A, operand B, opcode.
- Presents the operands and opcode to the ALU, samples the result and hands it to the UART transmitter with a start pulse.
- Waits for transmit completion before accepting the next frame.

Parameters:
- NB_DATA, 8, width of operands, result and UART byte.
- NB_OP, 6, width of ALU opcode (low bits of the third byte).
- TIMEOUT_TICKS, 50_000_000, idle-cycle limit for a partial frame (used only with the optional feature).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  synchronous reset, active-high.
- i_rx_done  in  1  one-cycle pulse: i_rx_data holds a new received byte.
- i_rx_data  in  NB_DATA  received byte from UART RX.
- i_tx_done  in  1  one-cycle pulse: UART TX finished the stop bit.
- i_alu_result  in  NB_DATA  combinational ALU output.
- o_alu_a  out  NB_DATA  registered operand A.
- o_alu_b  out  NB_DATA  registered operand B.
- o_alu_op  out  NB_OP  registered opcode.
- o_tx_start  out  1  one-cycle pulse requesting transmission.
- o_tx_data  out  NB_DATA  byte to transmit; stable from the o_tx_start cycle until i_tx_done.
- o_err  out  1  one-cycle pulse: invalid opcode or (optional) timeout, frame discarded.

Behaviour:
- Reset (sync, active-high): state=WAIT_A; o_alu_a, o_alu_b, o_alu_op, o_tx_data=0; o_tx_start=0; o_err=0. Reset overrides every event in the same cycle, including mid-frame and mid-transmission. A frame in progress is discarded.
- State WAIT_A: on i_rx_done, latch i_rx_data into o_alu_a, then go to WAIT_B.
- State WAIT_B: on i_rx_done, latch into o_alu_b, then go to WAIT_OP.
- State WAIT_OP: on i_rx_done, check i_rx_data[7:6]==0 and i_rx_data[5:0] in the valid set.
  - Valid opcodes: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRA 0x03, SRL 0x02.
  - Valid: latch i_rx_data[5:0] into o_alu_op, then go to EXEC.
  - Invalid: o_alu_op unchanged; o_err=1 for one cycle; go to WAIT_A.
- State EXEC (1 cycle, ALU settles): register i_alu_result into o_tx_data, drive o_tx_start=1 on the next cycle, go to SEND.
- State SEND (1 cycle): o_tx_start=1, then go to WAIT_TX.
- State WAIT_TX: o_tx_start=0; on i_tx_done, go to WAIT_A.
- Latency: the opcode i_rx_done pulse at cycle N gives o_tx_start high at cycle N+2.
- Bytes arriving in EXEC, SEND or WAIT_TX are dropped silently and do not start a new frame.
- i_tx_done outside WAIT_TX is ignored.
- Operands stay on the ALU ports until overwritten by the next frame. o_alu_a may change while o_alu_b still holds the old value; the ALU result is only sampled in EXEC.
- o_tx_start and o_err are never both high in the same cycle.

Optional Feature:
- Macro: UART_ALU_INTF_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_B and WAIT_OP. It clears on every i_rx_done and on every state entry.
  - At TIMEOUT_TICKS cycles without a byte: o_err pulse, partial frame discarded, go to WAIT_A.
  - The counter is not active in WAIT_A or the TX states.
- Undefined: no counter logic; a partial frame waits indefinitely.

Decomposition:
- Package uart_alu_pkg holds:
  - opcode localparams (OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL);
  - NB_DATA/NB_OP defaults;
  - state encoding (WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND, WAIT_TX);
  - the opcode-valid function.
- Sub-module intf_timeout (counter with clear/enable/expire pulse), instantiated only under UART_ALU_INTF_TIMEOUT_EN.

Test Plan:
- RX 22, 18, 0x20; ALU model adds -> op latched as 0x20, o_tx_start single pulse 2 cycles after third i_rx_done, o_tx_data=40. After i_tx_done, state=WAIT_A.
- RX 18, 22, 0x22 -> o_tx_data=0xFC (8-bit wrap). Then RX 0xF0, 0x0F, 0x27 -> o_tx_data=0x00.
- RX 5, 6, 0x3F -> o_err pulse, no o_tx_start, o_alu_op keeps its previous value. Next frame 1, 2, 0x20 -> o_tx_data=3.
- i_rx_done with 0x55 during WAIT_TX, then i_tx_done, then frame 7, 1, 0x22 -> byte 0x55 ignored, o_tx_data=6.
- i_reset asserted after operand A=9 -> all outputs 0. Frame 4, 4, 0x24 afterwards -> o_tx_data=4.
- (UART_ALU_INTF_TIMEOUT_EN, TIMEOUT_TICKS=100) RX A only, idle 100 cycles -> o_err pulse at cycle 100, state WAIT_A. Idle 99 cycles then B -> no error.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// uart_alu_pkg: shared definitions for the UART <-> ALU glue stage.
//   - NB_DATA_DEF / NB_OP_DEF : default operand and opcode widths
//   - OP_* localparams        : ALU opcodes accepted from the UART stream
//   - state_t                 : frame-collection / transmit FSM encoding
//   - opcode_valid()          : checks a raw received byte against the opcode set
package uart_alu_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  // The two top bits of the opcode byte must be zero; the low six bits
  // must name one of the supported ALU operations.
  function automatic logic opcode_valid(input logic [7:0] rx_byte);
    logic ok;
    ok = 1'b0;
    if (rx_byte[7:6] == 2'b00) begin
      case (rx_byte[5:0])
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_NOR, OP_SRA, OP_SRL: ok = 1'b1;
        default:                        ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/intf_timeout.sv
// intf_timeout: idle-cycle watchdog for a partially received frame.
// Only compiled when UART_ALU_INTF_TIMEOUT_EN is defined; in the default
// build this file contributes no module.
//   i_clock   : system clock
//   i_reset   : synchronous active-high reset
//   i_clear   : restart the count (a byte arrived)
//   i_enable  : count only while high; low also holds the count at zero
//   o_expire  : combinational pulse in the TICKS-th consecutive idle cycle
`ifdef UART_ALU_INTF_TIMEOUT_EN
module intf_timeout #(
  parameter int TICKS = 50_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] cnt_q;

  // Dropping out of the enabled states zeroes the count, so every entry
  // into a counting state starts from zero.
  always_ff @(posedge i_clock) begin
    if (i_reset || !i_enable || i_clear) begin
      cnt_q <= '0;
    end else if (!o_expire) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_expire = i_enable && !i_clear && (cnt_q == LAST);

endmodule
`endif

// File: rtl/uart_alu_intf.sv
// uart_alu_intf: glue between UART RX/TX and a combinational ALU.
// Collects operand A, operand B and opcode bytes, drives the ALU, samples
// its result and hands it to UART TX with a one-cycle start pulse, then
// waits for TX completion before accepting the next frame.
// Optional: UART_ALU_INTF_TIMEOUT_EN adds an idle watchdog that discards a
// partial frame after TIMEOUT_TICKS cycles in WAIT_B/WAIT_OP.
// Ports:
//   i_clock, i_reset     : clock, synchronous active-high reset
//   i_rx_done, i_rx_data : received-byte strobe and byte
//   i_tx_done            : UART TX finished the stop bit
//   i_alu_result         : combinational ALU output
//   o_alu_a/b/op         : registered ALU operands and opcode
//   o_tx_start/o_tx_data : transmit request pulse and byte
//   o_err                : invalid opcode / timeout pulse, frame discarded
module uart_alu_intf
  import uart_alu_pkg::*;
#(
  parameter int NB_DATA       = NB_DATA_DEF,
  parameter int NB_OP         = NB_OP_DEF,
  parameter int TIMEOUT_TICKS = 50_000_000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_err
);

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] alu_a_d, alu_b_d, tx_data_d;
  logic [NB_OP-1:0]   alu_op_d;
  logic               tx_start_d, err_d;
  logic               tmo_expire;

`ifdef UART_ALU_INTF_TIMEOUT_EN
  intf_timeout #(
    .TICKS    (TIMEOUT_TICKS)
  ) u_timeout (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_clear  (i_rx_done),
    .i_enable ((state_q == WAIT_B) || (state_q == WAIT_OP)),
    .o_expire (tmo_expire)
  );
`else
  // Keeps the parameter referenced in builds without the watchdog.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_TICKS != 0);
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    alu_a_d   = o_alu_a;
    alu_b_d   = o_alu_b;
    alu_op_d  = o_alu_op;
    tx_data_d = o_tx_data;
    err_d     = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (i_rx_done) begin
          alu_a_d = i_rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          alu_b_d = i_rx_data;
          state_d = WAIT_OP;
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          state_d = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          if (opcode_valid(i_rx_data[7:0])) begin
            alu_op_d = i_rx_data[NB_OP-1:0];
            state_d  = EXEC;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_A;
          end
        end else if (tmo_expire) begin
          err_d   = 1'b1;
          state_d = WAIT_A;
        end
      end
      // ALU inputs have been stable for a full cycle here; capture result.
      EXEC: begin
        tx_data_d = i_alu_result;
        state_d   = SEND;
      end
      SEND:    state_d = WAIT_TX;
      WAIT_TX: if (i_tx_done) state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
    // Start is registered from the next state so it is high exactly while in SEND.
    tx_start_d = (state_d == SEND);
  end

  // ---- register stage: FSM state and all outputs ----
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= WAIT_A;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state_q    <= state_d;
      o_alu_a    <= alu_a_d;
      o_alu_b    <= alu_b_d;
      o_alu_op   <= alu_op_d;
      o_tx_data  <= tx_data_d;
      o_tx_start <= tx_start_d;
      o_err      <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_alu_intf.sv
// Self-checking bench for uart_alu_intf with a behavioural ALU model.
// Define UART_ALU_INTF_TIMEOUT_EN to also exercise the idle watchdog.
module tb_uart_alu_intf;
  import uart_alu_pkg::*;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_rx_done;
  logic [7:0] i_rx_data;
  logic       i_tx_done;
  logic [7:0] i_alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_err;

  int checks = 0;
  int failures = 0;

  always #5 i_clock = ~i_clock;

  uart_alu_intf #(
    .NB_DATA       (8),
    .NB_OP         (6),
    .TIMEOUT_TICKS (100)
  ) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_rx_done    (i_rx_done),
    .i_rx_data    (i_rx_data),
    .i_tx_done    (i_tx_done),
    .i_alu_result (i_alu_result),
    .o_alu_a      (o_alu_a),
    .o_alu_b      (o_alu_b),
    .o_alu_op     (o_alu_op),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_err        (o_err)
  );

  // Combinational ALU model
  always_comb begin
    case (o_alu_op)
      6'h20:   i_alu_result = o_alu_a + o_alu_b;
      6'h22:   i_alu_result = o_alu_a - o_alu_b;
      6'h24:   i_alu_result = o_alu_a & o_alu_b;
      6'h25:   i_alu_result = o_alu_a | o_alu_b;
      6'h26:   i_alu_result = o_alu_a ^ o_alu_b;
      6'h27:   i_alu_result = ~(o_alu_a | o_alu_b);
      6'h03:   i_alu_result = $unsigned($signed(o_alu_a) >>> o_alu_b);
      6'h02:   i_alu_result = o_alu_a >> o_alu_b;
      default: i_alu_result = 8'h00;
    endcase
  end

  task automatic rx_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge i_clock); #1;
    i_rx_done = 1'b0;
  endtask

  task automatic tx_complete();
    i_tx_done = 1'b1;
    @(posedge i_clock); #1;
    i_tx_done = 1'b0;
  endtask

  // Sends a full frame and samples the three cycles after the opcode byte.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           output logic pre, output logic pulse, output logic post,
                           output logic err0, output logic err1,
                           output logic [7:0] data, output logic [5:0] opq);
    rx_byte(a);
    rx_byte(b);
    rx_byte(op);
    pre  = o_tx_start;
    err0 = o_err;
    opq  = o_alu_op;
    @(posedge i_clock); #1;
    pulse = o_tx_start;
    err1  = o_err;
    data  = o_tx_data;
    @(posedge i_clock); #1;
    post = o_tx_start;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_rx_done = 1'b0; i_rx_data = 8'h00; i_tx_done = 1'b0;
    repeat (2) @(posedge i_clock);
    #1;
    checks++; if (o_alu_a !== 8'h00) begin failures++; $display("FAIL reset_a: got %h expected 00", o_alu_a); end
    checks++; if (o_alu_b !== 8'h00) begin failures++; $display("FAIL reset_b: got %h expected 00", o_alu_b); end
    checks++; if (o_alu_op !== 6'h00) begin failures++; $display("FAIL reset_op: got %h expected 00", o_alu_op); end
    checks++; if (o_tx_data !== 8'h00) begin failures++; $display("FAIL reset_txdata: got %h expected 00", o_tx_data); end
    checks++; if (o_tx_start !== 1'b0) begin failures++; $display("FAIL reset_txstart: got %b expected 0", o_tx_start); end
    checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", o_err); end
    checks++; if (dut.state_q !== WAIT_A) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dut.state_q, WAIT_A); end
    i_reset = 1'b0;
    @(posedge i_clock); #1;
  endtask

  task automatic test_add();
    logic pre, pulse, post, e0, e1; logic [7:0] d; logic [5:0] op;
    run_frame(8'd22, 8'd18, 8'h20, pre, pulse, post, e0, e1, d, op);
    checks++; if (o_alu_a !== 8'd22 || o_alu_b !== 8'd18) begin failures++; $display("FAIL add_operands: got %0d,%0d expected 22,18", o_alu_a, o_alu_b); end
    checks++; if (op !== 6'h20) begin failures++; $display("FAIL add_op: got %h expected 20", op); end
    checks++; if (pre !== 1'b0) begin failures++; $display("FAIL add_start_early: got %b expected 0", pre); end
    checks++; if (pulse !== 1'b1) begin failures++; $display("FAIL add_start_pulse: got %b expected 1", pulse); end
    checks++; if (post !== 1'b0) begin failures++; $display("FAIL add_start_single: got %b expected 0", post); end
    checks++; if (d !== 8'd40) begin failures++; $display("FAIL add_data: got %0d expected 40", d); end
    checks++; if (e0 !== 1'b0 || e1 !== 1'b0) begin failures++; $display("FAIL add_err: got %b%b expected 00", e0, e1); end
    checks++; if (o_tx_data !== 8'd40) begin failures++; $display("FAIL add_data_hold: got %0d expected 40", o_tx_data); end
    tx_complete();
    checks++; if (dut.state_q !== WAIT_A) begin failures++; $display("FAIL add_state_after_tx: got %0d expected %0d", dut.state_q, WAIT_A); end
  endtask

  task automatic test_sub_nor();
    logic pre, pulse, post, e0, e1; logic [7:0] d; logic [5:0] op;
    run_frame(8'd18, 8'd22, 8'h22, pre, pulse, post, e0, e1, d, op);
    checks++; if (pulse !== 1'b1 || d !== 8'hFC) begin failures++; $display("FAIL sub_wrap: got start=%b data=%h expected 1,fc", pulse, d); end
    tx_complete();
    run_frame(8'hF0, 8'h0F, 8'h27, pre, pulse, post, e0, e1, d, op);
    checks++; if (op !== 6'h27) begin failures++; $display("FAIL nor_op: got %h expected 27", op); end
    checks++; if (pulse !== 1'b1 || d !== 8'h00) begin failures++; $display("FAIL nor_data: got start=%b data=%h expected 1,00", pulse, d); end
    tx_complete();
  endtask

  task automatic test_invalid_op();
    logic pre, pulse, post, e0, e1; logic [7:0] d; logic [5:0] op;
    run_frame(8'd5, 8'd6, 8'h3F, pre, pulse, post, e0, e1, d, op);
    checks++; if (e0 !== 1'b1) begin failures++; $display("FAIL inv_err: got %b expected 1", e0); end
    checks++; if (e1 !== 1'b0) begin failures++; $display("FAIL inv_err_single: got %b expected 0", e1); end
    checks++; if (pre !== 1'b0 || pulse !== 1'b0 || post !== 1'b0) begin failures++; $display("FAIL inv_no_start: got %b%b%b expected 000", pre, pulse, post); end
    checks++; if (op !== 6'h27) begin failures++; $display("FAIL inv_op_kept: got %h expected 27", op); end
    checks++; if (dut.state_q !== WAIT_A) begin failures++; $display("FAIL inv_state: got %0d expected %0d", dut.state_q, WAIT_A); end
    run_frame(8'd1, 8'd2, 8'h20, pre, pulse, post, e0, e1, d, op);
    checks++; if (pulse !== 1'b1 || d !== 8'd3) begin failures++; $display("FAIL inv_recover: got start=%b data=%0d expected 1,3", pulse, d); end
    // Left in WAIT_TX on purpose for the next scenario.
  endtask

  task automatic test_drop_in_wait_tx();
    logic pre, pulse, post, e0, e1; logic [7:0] d; logic [5:0] op;
    rx_byte(8'h55);
    checks++; if (o_alu_a !== 8'd1) begin failures++; $display("FAIL drop_a: got %h expected 01", o_alu_a); end
    checks++; if (dut.state_q !== WAIT_TX) begin failures++; $display("FAIL drop_state: got %0d expected %0d", dut.state_q, WAIT_TX); end
    tx_complete();
    run_frame(8'd7, 8'd1, 8'h22, pre, pulse, post, e0, e1, d, op);
    checks++; if (o_alu_a !== 8'd7) begin failures++; $display("FAIL drop_next_a: got %0d expected 7", o_alu_a); end
    checks++; if (pulse !== 1'b1 || d !== 8'd6) begin failures++; $display("FAIL drop_next_data: got start=%b data=%0d expected 1,6", pulse, d); end
    tx_complete();
    // tx_done while idle must be ignored
    tx_complete();
    checks++; if (dut.state_q !== WAIT_A || o_tx_start !== 1'b0) begin failures++; $display("FAIL stray_txdone: got state=%0d start=%b expected %0d,0", dut.state_q, o_tx_start, WAIT_A); end
  endtask

  task automatic test_reset_mid_frame();
    logic pre, pulse, post, e0, e1; logic [7:0] d; logic [5:0] op;
    rx_byte(8'd9);
    checks++; if (o_alu_a !== 8'd9) begin failures++; $display("FAIL mid_a: got %0d expected 9", o_alu_a); end
    i_reset = 1'b1;
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    checks++; if (o_alu_a !== 8'h00 || o_alu_b !== 8'h00 || o_alu_op !== 6'h00 || o_tx_data !== 8'h00)
      begin failures++; $display("FAIL mid_reset_regs: got %h %h %h %h expected 00 00 00 00", o_alu_a, o_alu_b, o_alu_op, o_tx_data); end
    checks++; if (o_tx_start !== 1'b0 || o_err !== 1'b0 || dut.state_q !== WAIT_A)
      begin failures++; $display("FAIL mid_reset_ctrl: got start=%b err=%b state=%0d expected 0,0,%0d", o_tx_start, o_err, dut.state_q, WAIT_A); end
    run_frame(8'd4, 8'd4, 8'h24, pre, pulse, post, e0, e1, d, op);
    checks++; if (pulse !== 1'b1 || d !== 8'd4) begin failures++; $display("FAIL mid_next_data: got start=%b data=%0d expected 1,4", pulse, d); end
    tx_complete();
  endtask

`ifdef UART_ALU_INTF_TIMEOUT_EN
  task automatic test_timeout();
    int hit;
    hit = 0;
    rx_byte(8'd11);
    for (int i = 1; i <= 150; i++) begin
      @(posedge i_clock); #1;
      if (o_err === 1'b1 && hit == 0) hit = i;
    end
    checks++; if (hit !== 100) begin failures++; $display("FAIL tmo_cycle: got %0d expected 100", hit); end
    checks++; if (dut.state_q !== WAIT_A) begin failures++; $display("FAIL tmo_state: got %0d expected %0d", dut.state_q, WAIT_A); end
    hit = 0;
    rx_byte(8'd11);
    for (int i = 1; i <= 99; i++) begin
      @(posedge i_clock); #1;
      if (o_err === 1'b1) hit = 1;
    end
    rx_byte(8'd12);
    if (o_err === 1'b1) hit = 1;
    checks++; if (hit !== 0 || dut.state_q !== WAIT_OP) begin failures++; $display("FAIL tmo_edge: got err=%0d state=%0d expected 0,%0d", hit, dut.state_q, WAIT_OP); end
    rx_byte(8'h20);
    repeat (2) @(posedge i_clock);
    #1;
    checks++; if (o_tx_data !== 8'd23) begin failures++; $display("FAIL tmo_frame_data: got %0d expected 23", o_tx_data); end
    tx_complete();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub_nor();
    test_invalid_op();
    test_drop_in_wait_tx();
    test_reset_mid_frame();
`ifdef UART_ALU_INTF_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
